dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port data memory (word-indexed, combinational read, write on posedge clk).
- Master 0 is the core load/store path; master 1 is the program loader/debug port.
- Serialises requests with round-robin fairness, latches each command, drives the memory port for exactly one cycle, and returns read data with a completion pulse.
- Flags out-of-range addresses instead of touching memory.

Parameters:
- ADDR_W, 32, width of master and memory address buses (word index).
- DATA_W, 32, data width.
- DEPTH, 1024, number of memory words; addresses >= DEPTH are errors.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request; held with command fields until m0_gnt.
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 word address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  one-cycle pulse: master 0 command accepted.
- m0_done  out  1  one-cycle pulse: master 0 access complete.
- m0_rdata  out  DATA_W  read data, valid while m0_done=1.
- m0_err  out  1  address error, valid while m0_done=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata, m1_err: identical for master 1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory combinational read data.
- busy  out  1  high when state != IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata and the winner id, set oob = (addr >= DEPTH), and go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS (exactly one cycle):
  - Registered gnt of the winner = 1.
  - mem_addr/mem_wdata come from the latched command.
  - mem_we = latched we AND NOT oob.
  - Read data: capture mem_rdata into the rdata register, or 0 if oob.
  - Next state is RESP.
- RESP (exactly one cycle):
  - Winner's done = 1, rdata valid, err = oob.
  - Next state is always IDLE.
- Request sampling and timing:
  - req is sampled only in IDLE.
  - Each access occupies 3 cycles; gnt occurs 1 cycle after req is sampled and done 2 cycles after.
  - A master must drop req by the edge ending its RESP cycle unless issuing a new access; a req still high in the next IDLE counts as a new request.
- Arbitration:
  - Single req wins immediately.
  - When both reqs are high, grant the master that was not granted last.
  - The last-grant pointer updates on the IDLE->ACCESS transition.
  - The reset value of the pointer is 1, so master 0 wins the first tie.
  - No starvation: under continuous double requests, grants alternate 0,1,0,1.
- Output rules:
  - gnt, done and err of the non-winning master stay 0.
  - m0_rdata/m1_rdata are each 0 except during their own done cycle.
  - mem_we is 0 in IDLE and RESP. mem_addr/mem_wdata hold the last latched values outside ACCESS.
- Writes: done with err=0, and rdata = 0. Oob writes: no mem_we, err=1.
- Reset (asynchronous, rst_n=0):
  - Immediately: state=IDLE, all gnt/done/err/busy/mem_we=0, all rdata=0, latched addr/wdata=0, pointer=1.
  - Reset during ACCESS aborts the write before the clock edge, so memory is not modified.
  - No done is issued for an aborted access.

Test Plan:
- Bench memory model preloaded with word1=200, word4=500. m0 read addr 1 -> m0_gnt in cycle 1, m0_done with m0_rdata=200 in cycle 2, m1 outputs quiet, busy high for cycles 1-2.
- m1 write addr 11 data 4000, then m0 read addr 11 -> mem_we high exactly one cycle; m0_rdata=4000; m1_err=0.
- m0 and m1 both req (reads of addr 1 and addr 4) from reset, held continuously -> grant order m0, m1, m0, m1; done values 200, 500, alternating; 3-cycle spacing.
- m0 write addr 1024 data 7 -> mem_we never asserted; m0_done with m0_err=1, rdata=0; a following read of addr 1 returns 200.
- rst_n driven low mid-ACCESS of an m1 write of 9 to addr 2 -> mem_we drops asynchronously; word2 unchanged; no m1_done; busy=0; after release a tie grants m0 first.
- Idle with no req for 10 cycles -> busy=0 and mem_we=0 throughout, all gnt/done=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and sequencer for a single-port, word-indexed data memory.
// Each access runs IDLE -> ACCESS -> RESP. Out-of-range addresses are reported as errors and never reach memory.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    state_t            state;
    logic              win;
    logic              last_gnt;
    logic              lat_we;
    logic              oob;
    logic              pick;
    logic              sel_we;
    logic              sel_oob;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_val;

    // On a tie the master that was not granted last wins.
    always_comb begin
        pick = m1_req;
        if (m0_req && m1_req) begin
            pick = ~last_gnt;
        end
        sel_we    = pick ? m1_we    : m0_we;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_oob   = (sel_addr >= LIMIT);
        rd_val    = (lat_we || oob) ? '0 : mem_rdata;
    end

    assign busy = (state != IDLE);

    // mem_addr/mem_wdata double as the latched command; mem_we is a register so reset aborts a write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win       <= 1'b0;
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            oob       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            mem_we   <= 1'b0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        win       <= pick;
                        last_gnt  <= pick;
                        lat_we    <= sel_we;
                        oob       <= sel_oob;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we & ~sel_oob;
                        m0_gnt    <= ~pick;
                        m1_gnt    <= pick;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (win) begin
                        m1_done  <= 1'b1;
                        m1_err   <= oob;
                        m1_rdata <= rd_val;
                    end else begin
                        m0_done  <= 1'b1;
                        m0_err   <= oob;
                        m0_rdata <= rd_val;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model schedules the expected per-cycle outputs,
// a compare process checks them every cycle, and directed scenarios pin the model with literal values.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, busy;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bench memory: combinational read, write on the rising edge.
    logic [31:0] mem [0:1023];
    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'd0;
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each accepted command books its gnt/done cycles in a schedule.
    typedef struct packed {
        bit g0, g1, d0, d1, e0, e1, bz, we;
        logic [31:0] r0, r1;
    } exp_t;

    exp_t        sched [int];
    int          pw_addr [int];
    logic [31:0] pw_data [int];
    logic [31:0] ref_mem [int];
    int          cyc = 0;
    int          next_free = 0;
    bit          last = 1'b1;

    function automatic exp_t getExp(input int k);
        exp_t e;
        e = '0;
        if (sched.exists(k)) e = sched[k];
        return e;
    endfunction

    always @(posedge clk) begin : model
        exp_t a, b;
        bit w, we;
        int addr;
        logic [31:0] wd, rv;
        bit oob;
        if (rst_n === 1'b1) begin
            if (pw_addr.exists(cyc)) ref_mem[pw_addr[cyc]] = pw_data[cyc];
            if (cyc >= next_free && (m0_req || m1_req)) begin
                w    = (m0_req && m1_req) ? !last : m1_req;
                last = w;
                we   = w ? m1_we : m0_we;
                addr = int'(w ? m1_addr : m0_addr);
                wd   = w ? m1_wdata : m0_wdata;
                oob  = (w ? m1_addr : m0_addr) >= 32'd1024;
                rv   = 32'd0;
                if (!we && !oob && ref_mem.exists(addr)) rv = ref_mem[addr];
                a = getExp(cyc + 1);
                b = getExp(cyc + 2);
                a.bz = 1; b.bz = 1;
                if (w) begin a.g1 = 1; b.d1 = 1; b.e1 = oob; b.r1 = rv; end
                else   begin a.g0 = 1; b.d0 = 1; b.e0 = oob; b.r0 = rv; end
                if (we && !oob) begin
                    a.we = 1;
                    pw_addr[cyc + 1] = addr;
                    pw_data[cyc + 1] = wd;
                end
                sched[cyc + 1] = a;
                sched[cyc + 2] = b;
                next_free = cyc + 3;
            end
        end
        cyc++;
    end

    always @(negedge rst_n) begin
        sched.delete();
        pw_addr.delete();
        pw_data.delete();
        next_free = 0;
        last = 1'b1;
    end

    // Per-cycle comparison of every output against the schedule.
    always @(negedge clk) begin : compare
        exp_t e;
        e = getExp(cyc);
        checkOutput("m0_gnt", {31'd0, m0_gnt}, {31'd0, e.g0});
        checkOutput("m1_gnt", {31'd0, m1_gnt}, {31'd0, e.g1});
        checkOutput("m0_done", {31'd0, m0_done}, {31'd0, e.d0});
        checkOutput("m1_done", {31'd0, m1_done}, {31'd0, e.d1});
        checkOutput("m0_err", {31'd0, m0_err}, {31'd0, e.e0});
        checkOutput("m1_err", {31'd0, m1_err}, {31'd0, e.e1});
        checkOutput("m0_rdata", m0_rdata, e.r0);
        checkOutput("m1_rdata", m1_rdata, e.r1);
        checkOutput("busy", {31'd0, busy}, {31'd0, e.bz});
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e.we});
    end

    // Event log used by the literal scenario checks.
    int          gq[$];
    int          gcyc[$];
    logic [31:0] dq[$];
    int          we_cnt = 0;
    int          m1_done_cnt = 0;
    int          ev_cnt = 0;
    always @(negedge clk) begin
        if (m0_gnt) begin gq.push_back(0); gcyc.push_back(cyc); end
        if (m1_gnt) begin gq.push_back(1); gcyc.push_back(cyc); end
        if (m0_done) dq.push_back(m0_rdata);
        if (m1_done) dq.push_back(m1_rdata);
        if (mem_we) we_cnt++;
        if (m1_done) m1_done_cnt++;
        if (m0_gnt || m1_gnt || m0_done || m1_done) ev_cnt++;
    end

    task automatic setMaster(input bit m, input bit req, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd);
        if (m) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; end
        else   begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; end
    endtask

    // One access by one master; waits (bounded) for gnt, then done.
    task automatic applyStimulus(input bit m, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit err);
        bit got;
        rd = 32'hdead_beef;
        err = 1'b0;
        @(posedge clk); #2;
        setMaster(m, 1'b1, we, addr, wd);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((m ? m1_gnt : m0_gnt) === 1'b1) got = 1;
        end
        if (!got) begin
            checkOutput("gnt_timeout", 32'd0, 32'd1);
            setMaster(m, 1'b0, 1'b0, 32'd0, 32'd0);
            return;
        end
        @(posedge clk); #2;
        setMaster(m, 1'b0, 1'b0, 32'd0, 32'd0);
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            if ((m ? m1_done : m0_done) === 1'b1) begin
                got = 1;
                rd  = m ? m1_rdata : m0_rdata;
                err = m ? m1_err : m0_err;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        bit          err;
        int          n0, w0, d0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[1] = 32'd200; mem[4] = 32'd500; mem[2] = 32'd33;
        ref_mem[1] = 32'd200; ref_mem[4] = 32'd500; ref_mem[2] = 32'd33;
        rst_n = 1'b0;
        setMaster(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setMaster(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] single read by m0");
        gq.delete(); gcyc.delete(); dq.delete();
        applyStimulus(1'b0, 1'b0, 32'd1, 32'd0, rd, err);
        checkOutput("t1_rdata", rd, 32'd200);
        checkOutput("t1_err", {31'd0, err}, 32'd0);
        checkOutput("t1_gnt_count", gq.size(), 32'd1);
        if (gq.size() > 0) checkOutput("t1_gnt_master", gq[0], 32'd0);

        $display("[TB] m1 write then m0 read back");
        w0 = we_cnt;
        applyStimulus(1'b1, 1'b1, 32'd11, 32'd4000, rd, err);
        checkOutput("t2_wr_err", {31'd0, err}, 32'd0);
        checkOutput("t2_wr_rdata", rd, 32'd0);
        checkOutput("t2_we_cycles", we_cnt - w0, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd11, 32'd0, rd, err);
        checkOutput("t2_rd_rdata", rd, 32'd4000);

        $display("[TB] continuous tie from reset");
        doReset();
        gq.delete(); gcyc.delete(); dq.delete();
        @(posedge clk); #2;
        setMaster(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        setMaster(1'b1, 1'b1, 1'b0, 32'd4, 32'd0);
        repeat (12) @(posedge clk);
        #2;
        setMaster(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setMaster(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        checkOutput("t3_gnt_count", gq.size(), 32'd4);
        checkOutput("t3_done_count", dq.size(), 32'd4);
        if (gq.size() == 4 && dq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("t3_order", gq[i], (i % 2 == 0) ? 32'd0 : 32'd1);
                checkOutput("t3_data", dq[i], (i % 2 == 0) ? 32'd200 : 32'd500);
            end
            for (int i = 0; i < 3; i++) checkOutput("t3_spacing", gcyc[i + 1] - gcyc[i], 32'd3);
        end

        $display("[TB] out-of-range write by m0");
        w0 = we_cnt;
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'd7, rd, err);
        checkOutput("t4_err", {31'd0, err}, 32'd1);
        checkOutput("t4_rdata", rd, 32'd0);
        checkOutput("t4_no_we", we_cnt - w0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd1, 32'd0, rd, err);
        checkOutput("t4_readback", rd, 32'd200);

        $display("[TB] reset during m1 write access");
        d0 = m1_done_cnt;
        @(posedge clk); #2;
        setMaster(1'b1, 1'b1, 1'b1, 32'd2, 32'd9);
        @(posedge clk); #2;
        checkOutput("t5_we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        setMaster(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput("t5_we_async", {31'd0, mem_we}, 32'd0);
        checkOutput("t5_busy_async", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        checkOutput("t5_word2", mem[2], 32'd33);
        checkOutput("t5_no_done", m1_done_cnt - d0, 32'd0);
        gq.delete(); gcyc.delete(); dq.delete();
        @(posedge clk); #2;
        setMaster(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        setMaster(1'b1, 1'b1, 1'b0, 32'd4, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        setMaster(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setMaster(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        checkOutput("t5_tie_count", gq.size(), 32'd1);
        if (gq.size() > 0) checkOutput("t5_tie_first", gq[0], 32'd0);

        $display("[TB] idle for 10 cycles");
        n0 = ev_cnt;
        w0 = we_cnt;
        repeat (10) @(posedge clk);
        checkOutput("t6_no_events", ev_cnt - n0, 32'd0);
        checkOutput("t6_no_we", we_cnt - w0, 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
